// File: rtl/event_count_display.sv
// Binary-to-BCD converter (sequential double-dabble) driving a 3-digit multiplexed
// common-anode seven-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module event_count_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  count_in,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd_value,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [7:0]         last_conv, captured, shift_bin;
  logic [11:0]        scratch, scratch_adj;
  logic [2:0]         iter;
  logic [CNT_W-1:0]   refresh_cnt;
  logic [1:0]         digit_idx;
  logic [3:0]         nibble;
  logic               blank;
  logic [6:0]         seg_next;
  logic [2:0]         an_next;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_in != last_conv) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (iter == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction is applied before each shift, so eight shifts give the final BCD.
  always_comb begin
    scratch_adj = scratch;
    for (int unsigned d = 0; d < 3; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      bcd_value <= '0;
      last_conv <= '0;
      captured  <= '0;
      shift_bin <= '0;
      scratch   <= '0;
      iter      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE:  if (state_next == LOAD) busy <= 1'b1;
        LOAD: begin
          shift_bin <= count_in;
          captured  <= count_in;
          scratch   <= '0;
          iter      <= '0;
        end
        SHIFT: begin
          {scratch, shift_bin} <= {scratch_adj, shift_bin} << 1;
          iter                 <= iter + 3'd1;
        end
        DONE: begin
          bcd_value <= scratch;
          last_conv <= captured;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    case (digit_idx)
      2'd1:    nibble = bcd_value[7:4];
      2'd2:    nibble = bcd_value[11:8];
      default: nibble = bcd_value[3:0];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    blank = ((digit_idx == 2'd2) && (bcd_value[11:8] == 4'd0)) ||
            ((digit_idx == 2'd1) && (bcd_value[11:4] == 8'd0));
`else
    blank = 1'b0;
`endif
    seg_next = blank ? 7'b1111111 : decode(nibble);
    case (digit_idx)
      2'd1:    an_next = 3'b101;
      2'd2:    an_next = 3'b011;
      default: an_next = 3'b110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 3'b110;
      seg <= 7'b1000000;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
